sim_exit_monitor: RTL and testbench

//  Lives inside the test harness and produces the io_success bit consumed by the simulation top.

---
 rtl/sim_exit_monitor.sv | 133 +++++++++++++
 tb/tb_sim_exit_monitor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_exit_monitor.sv
// Harness-side exit monitor: decodes HTIF tohost exit writes and a
// progress watchdog into sticky pass/fail flags and a latched exit code.
module sim_exit_monitor #(
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       DATA_W          = 64,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR     = 32'h8000_1000,
  parameter int unsigned       DRAIN_CYCLES    = 16,
  parameter int unsigned       WATCHDOG_CYCLES = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_wr_valid,
  output logic                io_wr_ready,
  input  logic [ADDR_W-1:0]   io_wr_addr,
  input  logic [DATA_W-1:0]   io_wr_data,
  input  logic [DATA_W/8-1:0] io_wr_strb,
  input  logic                io_heartbeat,
  output logic                io_success,
  output logic                io_failure,
  output logic [31:0]         io_exit_code
);

  localparam int unsigned DR_W =
    (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int unsigned WD_W =
    (WATCHDOG_CYCLES > 0) ? $clog2(WATCHDOG_CYCLES + 1) : 1;

  localparam logic [DR_W:0] DR_LAST = (DR_W+1)'(DRAIN_CYCLES);
  localparam logic [WD_W:0] WD_LAST = (WD_W+1)'(WATCHDOG_CYCLES);
  localparam logic          WD_EN   = (WATCHDOG_CYCLES != 0);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_PASS  = 2'd2;
  localparam logic [1:0] S_FAIL  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [DR_W-1:0] drain_q, drain_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [31:0]     code_q, code_d;
  logic            succ_q, succ_d;
  logic            fail_q, fail_d;

  logic            accept;
  logic            is_exit;
  logic            code_zero;
  logic [31:0]     wr_code;
  logic [DR_W:0]   drain_inc;
  logic [WD_W:0]   wd_inc;
  logic [WD_W-1:0] wd_sat;
  logic            wd_expire;
  logic            unused_bits;

  assign io_wr_ready = !reset &&
    (state_q == S_RUN || state_q == S_DRAIN);

  assign accept    = io_wr_valid && io_wr_ready;
  assign wr_code   = io_wr_data[32:1];
  assign code_zero = (wr_code == 32'd0);
  assign is_exit   = accept
                  && (io_wr_addr == TOHOST_ADDR)
                  && (io_wr_strb[3:0] == 4'hF)
                  && io_wr_data[0];

  // Upper data/strobe bits only matter to the DUT, not to exit decode.
  assign unused_bits = ^{io_wr_data, io_wr_strb};

  assign drain_inc = {1'b0, drain_q} + {{DR_W{1'b0}}, 1'b1};
  assign wd_inc    = {1'b0, wd_q} + {{WD_W{1'b0}}, 1'b1};
  assign wd_sat    = (&wd_q) ? wd_q : wd_inc[WD_W-1:0];

  // Heartbeat wins over expiry in the same cycle.
  assign wd_expire = WD_EN && !io_heartbeat && (wd_inc >= WD_LAST);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    wd_d    = wd_q;
    code_d  = code_q;
    case (state_q)
      S_RUN: begin
        wd_d = (io_heartbeat || !WD_EN) ? '0 : wd_sat;
        if (is_exit && !code_zero) begin
          state_d = S_FAIL;
          code_d  = wr_code;
        end else if (is_exit) begin
          state_d = (DRAIN_CYCLES == 0) ? S_PASS : S_DRAIN;
        end else if (wd_expire) begin
          state_d = S_FAIL;
          code_d  = 32'hFFFF_FFFF;
        end
      end
      S_DRAIN: begin
        drain_d = drain_inc[DR_W-1:0];
        if (is_exit && !code_zero) begin
          state_d = S_FAIL;
          code_d  = wr_code;
        end else if (drain_inc >= DR_LAST) begin
          state_d = S_PASS;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  assign succ_d = (state_d == S_PASS);
  assign fail_d = (state_d == S_FAIL);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RUN;
      drain_q <= '0;
      wd_q    <= '0;
      code_q  <= 32'd0;
      succ_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      wd_q    <= wd_d;
      code_q  <= code_d;
      succ_q  <= succ_d;
      fail_q  <= fail_d;
    end
  end

  assign io_success   = succ_q;
  assign io_failure   = fail_q;
  assign io_exit_code = code_q;

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Bench for sim_exit_monitor: three configurations on shared stimulus,
// each checked every cycle against an event-time reference model.
module tb_sim_exit_monitor;

  localparam logic [31:0] TOHOST = 32'h8000_1000;

  logic        clock    = 1'b0;
  logic        reset    = 1'b1;
  logic        wr_valid = 1'b0;
  logic        hb       = 1'b0;
  logic [31:0] wr_addr  = '0;
  logic [63:0] wr_data  = '0;
  logic [7:0]  wr_strb  = '0;

  logic [2:0]  rdy, suc, fl;
  logic [31:0] cd [3];

  int checks = 0;
  int errors = 0;
  int t      = 0;

  int pd [3] = '{16, 3, 0};
  int pw [3] = '{0, 100, 0};

  // Model: fail flag + code, the cycle index at which PASS appears,
  // and the last cycle that restarted the quiet-cycle count.
  bit          m_fail     [3];
  logic [31:0] m_code     [3];
  int          m_pass_due [3];
  int          m_last_hb  [3];

  always #5 clock = ~clock;

  sim_exit_monitor #(.DRAIN_CYCLES(16), .WATCHDOG_CYCLES(0)) u0 (
    .clock(clock), .reset(reset),
    .io_wr_valid(wr_valid), .io_wr_ready(rdy[0]),
    .io_wr_addr(wr_addr), .io_wr_data(wr_data), .io_wr_strb(wr_strb),
    .io_heartbeat(hb), .io_success(suc[0]), .io_failure(fl[0]),
    .io_exit_code(cd[0])
  );

  sim_exit_monitor #(.DRAIN_CYCLES(3), .WATCHDOG_CYCLES(100)) u1 (
    .clock(clock), .reset(reset),
    .io_wr_valid(wr_valid), .io_wr_ready(rdy[1]),
    .io_wr_addr(wr_addr), .io_wr_data(wr_data), .io_wr_strb(wr_strb),
    .io_heartbeat(hb), .io_success(suc[1]), .io_failure(fl[1]),
    .io_exit_code(cd[1])
  );

  sim_exit_monitor #(.DRAIN_CYCLES(0), .WATCHDOG_CYCLES(0)) u2 (
    .clock(clock), .reset(reset),
    .io_wr_valid(wr_valid), .io_wr_ready(rdy[2]),
    .io_wr_addr(wr_addr), .io_wr_data(wr_data), .io_wr_strb(wr_strb),
    .io_heartbeat(hb), .io_success(suc[2]), .io_failure(fl[2]),
    .io_exit_code(cd[2])
  );

  function automatic bit passed(input int i);
    return !m_fail[i] && m_pass_due[i] >= 0 && t >= m_pass_due[i];
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic        e_rdy;
      logic [34:0] obs;
      logic [34:0] exp;
      e_rdy = !reset && !m_fail[i] && !passed(i);
      obs = {rdy[i], suc[i], fl[i], cd[i]};
      exp = {e_rdy, passed(i), m_fail[i], m_code[i]};
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL mon%0d t=%0d rdy/suc/fail/code got %b/%b/%b/%h want %b/%b/%b/%h",
               i, t, obs[34], obs[33], obs[32], obs[31:0],
               exp[34], exp[33], exp[32], exp[31:0]);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    bit          term;
    bit          ex;
    logic [31:0] c;
    term = m_fail[i] || passed(i);
    ex = wr_valid && wr_addr == TOHOST && wr_strb[3:0] == 4'hF
      && wr_data[0];
    c = wr_data[32:1];
    if (reset) begin
      m_fail[i]     = 1'b0;
      m_code[i]     = 32'd0;
      m_pass_due[i] = -1;
      m_last_hb[i]  = t;
    end else if (!term) begin
      if (ex && c != 32'd0) begin
        m_fail[i] = 1'b1;
        m_code[i] = c;
      end else if (ex && m_pass_due[i] < 0) begin
        m_pass_due[i] = t + 1 + pd[i];
      end else if (m_pass_due[i] < 0 && pw[i] != 0) begin
        if (hb) m_last_hb[i] = t;
        else if (t - m_last_hb[i] >= pw[i]) begin
          m_fail[i] = 1'b1;
          m_code[i] = 32'hFFFF_FFFF;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [31:0] a,
                     input logic [63:0] d, input logic [7:0] s,
                     input logic h);
    @(negedge clock);
    t++;
    check_all();
    reset    = r;
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    wr_strb  = s;
    hb       = h;
    for (int i = 0; i < 3; i++) model_step(i);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic rst();
    cyc(1'b1, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic exitw(input logic [31:0] code);
    cyc(1'b0, 1'b1, TOHOST, {31'h0, code, 1'b1}, 8'hFF, 1'b0);
  endtask

  initial begin
    int quiet_left;
    int kind;
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    for (int i = 0; i < 3; i++) begin
      m_fail[i] = 1'b0;
      m_code[i] = 32'd0;
      m_pass_due[i] = -1;
      m_last_hb[i] = 0;
    end

    // Pass path with drain latency
    rst();
    idle(8);
    exitw(32'd0);
    idle(20);
    chk("t1_success", {31'd0, suc[0]}, 32'd1);
    chk("t1_failure", {31'd0, fl[0]}, 32'd0);
    chk("t1_code", cd[0], 32'd0);

    // Failure code
    rst();
    idle(2);
    exitw(32'd3);
    idle(3);
    chk("t2_code", cd[0], 32'd3);
    chk("t2_ready", {31'd0, rdy[0]}, 32'd0);

    // Non-exit writes must be inert
    rst();
    idle(2);
    cyc(1'b0, 1'b1, 32'h8000_1008, 64'h1, 8'hFF, 1'b0);
    cyc(1'b0, 1'b1, TOHOST, 64'h2, 8'hFF, 1'b0);
    cyc(1'b0, 1'b1, TOHOST, 64'h1, 8'h0E, 1'b0);
    idle(3);
    chk("t3_ready", {29'd0, rdy}, 32'd7);

    // Watchdog: steady heartbeats, then silence
    rst();
    for (int k = 0; k < 1000; k++)
      cyc(1'b0, 1'b0, '0, '0, '0, (k % 50) == 0);
    chk("t4_alive", {31'd0, fl[1]}, 32'd0);
    idle(120);
    chk("t4_timeout", {31'd0, fl[1]}, 32'd1);
    chk("t4_code", cd[1], 32'hFFFF_FFFF);

    // Failure during drain; zero-drain passes immediately
    rst();
    idle(2);
    exitw(32'd0);
    idle(4);
    exitw(32'd5);
    idle(20);
    chk("t5_code", cd[0], 32'd5);
    chk("t5_nosucc", {31'd0, suc[0]}, 32'd0);
    chk("t5_d0_pass", {31'd0, suc[2]}, 32'd1);

    // Reset out of FAIL and out of DRAIN
    exitw(32'd9);
    rst();
    idle(2);
    exitw(32'd0);
    idle(5);
    rst();
    idle(2);
    exitw(32'd0);
    idle(20);
    chk("t6_success", {31'd0, suc[0]}, 32'd1);

    // Randomized traffic
    quiet_left = 0;
    for (int k = 0; k < 5000; k++) begin
      kind = $urandom_range(0, 99);
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      if (kind < 1) begin
        a = TOHOST;
        d = {31'($urandom), 32'd0, 1'b1};
      end else if (kind < 2) begin
        a = TOHOST;
        d = {31'($urandom), $urandom, 1'b1};
      end else if (kind < 30) begin
        a = TOHOST;
        d = {$urandom, $urandom};
        d[0] = d[0] & ($urandom_range(0, 9) == 0);
      end else begin
        a = TOHOST + 32'($urandom_range(0, 3) * 8);
        d = {$urandom, $urandom};
      end
      if ($urandom_range(0, 499) == 0) quiet_left = $urandom_range(80, 130);
      if (quiet_left > 0) quiet_left--;
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
          a, d, s,
          (quiet_left == 0) && ($urandom_range(0, 7) == 0));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
